vsc8541_mdio: RTL and testbench
===============================

Name: vsc8541_mdio

Overview:
- Clause-22 MDIO management master for the VSC8541 PHY.
- Runs once the PHY is out of hardware reset and its strap pins are latched.
- Issues single register read or write frames on MDC/MDIO for the upstream control logic.
- Returns read data and a turnaround-error flag.
- The tri-state MDIO pad buffer sits at top level; this block drives the out/oe pair and samples the in pin.

Parameters:
CLK_DIV, 25, clk cycles per MDC half-period (MDC period = 2*CLK_DIV; 50 MHz clk -> 1 MHz MDC); legal range >= 2
PRE_LEN, 32, preamble length in slots (all ones); legal range 0..32

Ports:
clk  in  1  system clock
i_nreset  in  1  asynchronous active-low reset
i_start  in  1  request; accepted only while o_busy=0
i_write  in  1  1=write frame, 0=read frame; latched on accept
i_phy_addr  in  5  PHYAD; latched on accept
i_reg_addr  in  5  REGAD; latched on accept
i_wdata  in  16  write data; latched on accept
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse at frame end
o_rdata  out  16  last read data; holds until the next read completes
o_rd_err  out  1  set if the PHY failed to drive TA bit 2 low on a read
o_mdc  out  1  management clock
o_mdio_out  out  1  MDIO output value
o_mdio_oe  out  1  MDIO output enable (1 = master drives)
i_mdio_in  in  1  MDIO pad input (asynchronous)

Behaviour:
- Clock and reset: one clock `clk`; reset `i_nreset` is asynchronous, active-low.
- Reset values: o_mdc=0, o_mdio_out=1, o_mdio_oe=0, o_busy=0, o_done=0, o_rdata=0, o_rd_err=0; state IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately; no o_done; the frame is abandoned.
- i_mdio_in passes through a 2-FF synchronizer before use.
- Slots: each slot is CLK_DIV cycles with MDC low, then CLK_DIV cycles with MDC high.
  - o_mdio_out/o_mdio_oe change only on the first cycle of a slot (MDC falling/low phase).
  - The synchronized input is sampled on the first MDC-high cycle of a slot.
- Frame = PRE_LEN + 32 slots, in this order:
  - preamble: PRE_LEN ones
  - ST: 01
  - OP: write 01, read 10
  - PHYAD[4:0], then REGAD[4:0], MSB first
  - TA: 2 slots
  - DATA[15:0], MSB first
- Write frame: oe=1 for every slot; TA drives 1,0; data is the latched i_wdata.
- Read frame:
  - oe=1 through REGAD[0].
  - oe=0 from TA slot 1 onward; o_mdio_out is held at 1 while oe=0.
  - TA slot 2 sample must be 0; otherwise o_rd_err=1 at frame end.
  - The 16 data samples shift into a register that loads o_rdata at frame end.
- States: IDLE -> PRE (skipped if PRE_LEN=0) -> HDR (14 slots: ST, OP, PHYAD, REGAD) -> TA (2) -> DATA (16) -> IDLE.
- Accept: in the cycle i_start=1 while IDLE:
  - latch the inputs; clear o_rd_err;
  - o_busy=1 from the next cycle;
  - the first slot begins that same next cycle.
- Frame end: the cycle after the last MDC-high cycle of DATA slot 15:
  - state returns to IDLE, o_busy=0, o_done=1 for one cycle, o_mdc=0, o_mdio_oe=0;
  - o_rdata and o_rd_err are valid in this cycle (read frames only).
  - A start asserted in this same cycle is accepted (back-to-back).
- Frame length: exactly (PRE_LEN+32)*2*CLK_DIV busy cycles.
- Ignored inputs: i_start while busy is ignored; input changes after accept have no effect.
- Write frames leave o_rdata and o_rd_err unchanged (o_rd_err was cleared at accept).

Decomposition:
- Package vsc8541_pkg holds:
  - ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10
  - HDR_SLOTS=14, TA_SLOTS=2, DATA_SLOTS=16
  - the mdio_state_t enum {IDLE, PRE, HDR, TA, DATA}
- One sub-module, mdc_gen:
  - divides clk and produces o_mdc plus one-cycle slot_start and rise strobes;
  - held idle (MDC low) when not enabled.
- The bit counter, shift registers and FSM live in the top.

Test Plan (CLK_DIV=2, PRE_LEN=32, i.e. 4-cycle slots and 256-cycle frames):
1. Reset held 5 cycles, then released -> all outputs at reset values; o_mdc stays 0 with no start.
2. Write phy=0x00, reg=0x1F, wdata=0x0010 -> serial stream of 32 ones, then 01 01 00000 11111 10 0000000000010000; oe=1 in all 64 slots; o_busy high 256 cycles; o_done pulse in cycle 257 after accept.
3. Read phy=0x00, reg=0x02; PHY model drives TA bit 2 = 0 and data 0x0007 -> oe drops at slot 46 (TA slot 1); o_rdata=0x0007, o_rd_err=0 at o_done.
4. Read with no PHY model (pad pulled up to 1) -> o_rdata=0xFFFF, o_rd_err=1; a following write then leaves o_rdata=0xFFFF and clears o_rd_err to 0.
5. i_start pulsed at slot 10 of a frame -> ignored, frame unchanged; i_start in the o_done cycle -> new frame starts next cycle, no MDC gap beyond one low phase.
6. i_nreset asserted during slot 20 of a read -> outputs return to reset values within the same cycle, no o_done; after release, a read of reg 0x03 completes normally.

Source files
------------

// File: rtl/vsc8541_pkg.sv
// Shared constants, FSM state type and frame payload for the VSC8541 MDIO master.
package vsc8541_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int unsigned HDR_SLOTS  = 14;
    localparam int unsigned TA_SLOTS   = 2;
    localparam int unsigned DATA_SLOTS = 16;
    localparam int unsigned FRAME_W    = HDR_SLOTS + TA_SLOTS + DATA_SLOTS;

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA} mdio_state_t;

    typedef struct packed {
        logic        write;
        logic [4:0]  phy_addr;
        logic [4:0]  reg_addr;
        logic [15:0] wdata;
    } mdio_req_t;

    // Post-preamble serial image; TA/DATA of a read are placeholders since oe is low there.
    function automatic logic [FRAME_W-1:0] build_frame(input mdio_req_t req);
        return {ST_CODE,
                req.write ? OP_WRITE : OP_READ,
                req.phy_addr,
                req.reg_addr,
                req.write ? TA_WRITE : 2'b11,
                req.write ? req.wdata : 16'hFFFF};
    endfunction

endpackage

// File: rtl/vsc8541_mdio_mdc_gen.sv
// MDC divider: CLK_DIV cycles low then CLK_DIV cycles high per slot; parked low when disabled.
module mdc_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic i_nreset,
    input  logic en,
    output logic o_mdc,
    output logic slot_start_c,
    output logic rise_c
);

    localparam int unsigned PH_W    = $clog2(2 * CLK_DIV);
    localparam int unsigned PH_LAST = 2 * CLK_DIV - 1;

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nxt;

    // Phase advance with wrap at the end of a slot
    always_comb begin
        ph_nxt = ph + PH_W'(1);
        if (ph == PH_W'(PH_LAST)) begin
            ph_nxt = '0;
        end
    end

    // Phase counter and registered MDC level for the upcoming cycle
    always_ff @(posedge clk or negedge i_nreset) begin
        if (!i_nreset) begin
            ph    <= '0;
            o_mdc <= 1'b0;
        end else if (en) begin
            ph    <= ph_nxt;
            o_mdc <= (ph_nxt >= PH_W'(CLK_DIV));
        end else begin
            ph    <= '0;
            o_mdc <= 1'b0;
        end
    end

    // slot_start_c marks the edge that opens the next slot; rise_c the first MDC-high cycle
    assign slot_start_c = en && (ph == PH_W'(PH_LAST));
    assign rise_c       = en && (ph == PH_W'(CLK_DIV));

endmodule

// File: rtl/vsc8541_mdio.sv
// Clause-22 MDIO master: one read or write frame per accepted request.
module vsc8541_mdio
    import vsc8541_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        i_nreset,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rdata,
    output logic        o_rd_err,
    output logic        o_mdc,
    output logic        o_mdio_out,
    output logic        o_mdio_oe,
    input  logic        i_mdio_in
);

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned PRE_LAST = (PRE_LEN > 0) ? PRE_LEN - 1 : 0;

    mdio_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] tx;
    logic [15:0]        rx;
    logic               is_wr;
    logic               ta_bit;
    logic               sync1;
    logic               sync2;
    logic               slot_start_c;
    logic               rise_c;
    mdio_req_t          req_c;
    logic [FRAME_W-1:0] frame_c;

    assign req_c   = '{write: i_write, phy_addr: i_phy_addr, reg_addr: i_reg_addr, wdata: i_wdata};
    assign frame_c = build_frame(req_c);

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk          (clk),
        .i_nreset     (i_nreset),
        .en           (o_busy),
        .o_mdc        (o_mdc),
        .slot_start_c (slot_start_c),
        .rise_c       (rise_c)
    );

    // Two-flop synchronizer for the asynchronous pad input (idles high like the pull-up)
    always_ff @(posedge clk or negedge i_nreset) begin
        if (!i_nreset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_mdio_in;
            sync2 <= sync1;
        end
    end

    // Frame sequencer: accept, slot-by-slot drive, sampling and completion
    always_ff @(posedge clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state      <= IDLE;
            cnt        <= '0;
            tx         <= '0;
            rx         <= '0;
            is_wr      <= 1'b0;
            ta_bit     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rdata    <= '0;
            o_rd_err   <= 1'b0;
            o_mdio_out <= 1'b1;
            o_mdio_oe  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                if (i_start) begin
                    is_wr     <= i_write;
                    o_rd_err  <= 1'b0;
                    o_busy    <= 1'b1;
                    o_mdio_oe <= 1'b1;
                    cnt       <= '0;
                    if (PRE_LEN != 0) begin
                        state      <= PRE;
                        tx         <= frame_c;
                        o_mdio_out <= 1'b1;
                    end else begin
                        state      <= HDR;
                        tx         <= {frame_c[FRAME_W-2:0], 1'b0};
                        o_mdio_out <= frame_c[FRAME_W-1];
                    end
                end
            end else begin
                if (rise_c) begin
                    if (state == TA && cnt == CNT_W'(TA_SLOTS - 1)) begin
                        ta_bit <= sync2;
                    end
                    if (state == DATA) begin
                        rx <= {rx[14:0], sync2};
                    end
                end
                if (slot_start_c) begin
                    cnt <= cnt + CNT_W'(1);
                    case (state)
                        PRE: begin
                            if (cnt == CNT_W'(PRE_LAST)) begin
                                state      <= HDR;
                                cnt        <= '0;
                                o_mdio_out <= tx[FRAME_W-1];
                                tx         <= {tx[FRAME_W-2:0], 1'b0};
                            end
                        end
                        HDR: begin
                            tx         <= {tx[FRAME_W-2:0], 1'b0};
                            o_mdio_out <= tx[FRAME_W-1];
                            if (cnt == CNT_W'(HDR_SLOTS - 1)) begin
                                state <= TA;
                                cnt   <= '0;
                                if (!is_wr) begin
                                    o_mdio_oe  <= 1'b0;
                                    o_mdio_out <= 1'b1;
                                end
                            end
                        end
                        TA: begin
                            tx <= {tx[FRAME_W-2:0], 1'b0};
                            if (is_wr) begin
                                o_mdio_out <= tx[FRAME_W-1];
                            end
                            if (cnt == CNT_W'(TA_SLOTS - 1)) begin
                                state <= DATA;
                                cnt   <= '0;
                            end
                        end
                        DATA: begin
                            tx <= {tx[FRAME_W-2:0], 1'b0};
                            if (is_wr) begin
                                o_mdio_out <= tx[FRAME_W-1];
                            end
                            if (cnt == CNT_W'(DATA_SLOTS - 1)) begin
                                state      <= IDLE;
                                cnt        <= '0;
                                o_busy     <= 1'b0;
                                o_done     <= 1'b1;
                                o_mdio_oe  <= 1'b0;
                                o_mdio_out <= 1'b1;
                                if (!is_wr) begin
                                    o_rdata  <= rx;
                                    o_rd_err <= ta_bit;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vsc8541_mdio.sv
// Randomized self-checking bench for vsc8541_mdio against a slot-level frame model.
module tb_vsc8541_mdio;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned PRE_LEN   = 32;
    localparam int unsigned SLOTS     = PRE_LEN + 32;
    localparam int unsigned CYC       = 2 * CLK_DIV;
    localparam int unsigned FRAME_CYC = SLOTS * CYC;

    logic        clk = 1'b0;
    logic        i_nreset;
    logic        i_start;
    logic        i_write;
    logic [4:0]  i_phy_addr;
    logic [4:0]  i_reg_addr;
    logic [15:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_rdata;
    logic        o_rd_err;
    logic        o_mdc;
    logic        o_mdio_out;
    logic        o_mdio_oe;
    logic        i_mdio_in;

    int vectors = 0;
    int errors  = 0;

    // Model of the externally visible read result registers
    logic [15:0] m_rdata = 16'h0000;
    logic        m_err   = 1'b0;

    vsc8541_mdio #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
        .clk        (clk),
        .i_nreset   (i_nreset),
        .i_start    (i_start),
        .i_write    (i_write),
        .i_phy_addr (i_phy_addr),
        .i_reg_addr (i_reg_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_rd_err   (o_rd_err),
        .o_mdc      (o_mdc),
        .o_mdio_out (o_mdio_out),
        .o_mdio_oe  (o_mdio_oe),
        .i_mdio_in  (i_mdio_in)
    );

    always #5 clk = ~clk;

    // One full frame from the accept cycle (caller is at a negedge) through the o_done cycle
    task automatic frame(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit phy_on, input bit ta_ok,
                         input logic [15:0] pdata, input int poke_slot, input bit b2b);
        logic        exp_out [SLOTS];
        logic        exp_oe  [SLOTS];
        logic        pad     [SLOTS];
        logic [31:0] fb;
        logic        exp_mdc;
        int          s;
        int          p;
        fb = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra, 2'b10, wd};
        for (int i = 0; i < int'(SLOTS); i++) begin
            pad[i] = 1'b1;
            exp_oe[i] = 1'b1;
            exp_out[i] = 1'b1;
        end
        for (int i = 0; i < 32; i++) begin
            exp_out[PRE_LEN + i] = fb[31 - i];
            if (!wr && i >= 14) begin
                exp_out[PRE_LEN + i] = 1'b1;
                exp_oe[PRE_LEN + i]  = 1'b0;
            end
        end
        if (!wr && phy_on) begin
            pad[PRE_LEN + 15] = ta_ok ? 1'b0 : 1'b1;
            for (int i = 0; i < 16; i++) pad[PRE_LEN + 16 + i] = pdata[15 - i];
        end
        if (wr) begin
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) m_rdata[15 - i] = pad[PRE_LEN + 16 + i];
            m_err = pad[PRE_LEN + 15];
        end

        i_write = wr; i_phy_addr = pa; i_reg_addr = ra; i_wdata = wd; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_write = 1'($urandom); i_phy_addr = 5'($urandom); i_reg_addr = 5'($urandom); i_wdata = 16'($urandom);
        for (int k = 1; k <= int'(FRAME_CYC); k++) begin
            s = (k - 1) / int'(CYC);
            p = (k - 1) % int'(CYC);
            exp_mdc = (p >= int'(CLK_DIV));
            vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy k=%0d got=%b exp=1", k, o_busy); end
            vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_early k=%0d got=%b exp=0", k, o_done); end
            vectors++; if (o_mdc !== exp_mdc) begin errors++; $display("FAIL mdc k=%0d got=%b exp=%b", k, o_mdc, exp_mdc); end
            vectors++; if (o_mdio_oe !== exp_oe[s]) begin errors++; $display("FAIL oe slot=%0d k=%0d got=%b exp=%b", s, k, o_mdio_oe, exp_oe[s]); end
            vectors++; if (o_mdio_out !== exp_out[s]) begin errors++; $display("FAIL out slot=%0d k=%0d got=%b exp=%b", s, k, o_mdio_out, exp_out[s]); end
            if (p == 0) i_mdio_in = pad[s];
            i_start = (s == poke_slot && p == 0);
            if (i_start) begin
                i_write = 1'($urandom); i_phy_addr = 5'($urandom); i_reg_addr = 5'($urandom); i_wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        i_mdio_in = 1'b1;
        vectors++; if (o_done !== 1'b1) begin errors++; $display("FAIL done got=%b exp=1", o_done); end
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_end got=%b exp=0", o_busy); end
        vectors++; if (o_mdc !== 1'b0) begin errors++; $display("FAIL mdc_end got=%b exp=0", o_mdc); end
        vectors++; if (o_mdio_oe !== 1'b0) begin errors++; $display("FAIL oe_end got=%b exp=0", o_mdio_oe); end
        vectors++; if (o_rdata !== m_rdata) begin errors++; $display("FAIL rdata got=%h exp=%h", o_rdata, m_rdata); end
        vectors++; if (o_rd_err !== m_err) begin errors++; $display("FAIL rd_err got=%b exp=%b", o_rd_err, m_err); end
        if (!b2b) begin
            @(negedge clk);
            vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", o_done); end
            vectors++; if (o_mdc !== 1'b0) begin errors++; $display("FAIL mdc_idle got=%b exp=0", o_mdc); end
        end
    endtask

    task automatic test_reset();
        i_nreset = 1'b0;
        repeat (5) @(negedge clk);
        i_nreset = 1'b1;
        @(negedge clk);
        vectors++; if (o_mdio_out !== 1'b1) begin errors++; $display("FAIL rst_out got=%b exp=1", o_mdio_out); end
        vectors++; if (o_mdio_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got=%b exp=0", o_mdio_oe); end
        vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", o_done); end
        vectors++; if (o_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", o_rdata); end
        vectors++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL rst_rd_err got=%b exp=0", o_rd_err); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (o_mdc !== 1'b0) begin errors++; $display("FAIL rst_mdc cyc=%0d got=%b exp=0", i, o_mdc); end
            vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy cyc=%0d got=%b exp=0", i, o_busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_write();
        frame(1'b1, 5'h00, 5'h1F, 16'h0010, 1'b0, 1'b0, 16'h0000, -1, 1'b0);
    endtask

    task automatic test_read();
        frame(1'b0, 5'h00, 5'h02, 16'h0000, 1'b1, 1'b1, 16'h0007, -1, 1'b0);
        vectors++; if (o_rdata !== 16'h0007) begin errors++; $display("FAIL read_const got=%h exp=0007", o_rdata); end
    endtask

    task automatic test_no_phy();
        frame(1'b0, 5'h05, 5'h01, 16'h0000, 1'b0, 1'b0, 16'h0000, -1, 1'b0);
        frame(1'b1, 5'h05, 5'h00, 16'($urandom), 1'b0, 1'b0, 16'h0000, -1, 1'b0);
        vectors++; if (o_rdata !== 16'hFFFF) begin errors++; $display("FAIL nophy_hold got=%h exp=ffff", o_rdata); end
    endtask

    task automatic test_ignore_start();
        frame(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0000, 10, 1'b0);
        frame(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 1'b1, 16'($urandom), 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        frame(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0000, -1, 1'b1);
        frame(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 1'b1, 16'($urandom), -1, 1'b1);
        frame(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 1'b0, 16'($urandom), -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            frame(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, SLOTS - 1)) : -1, 1'b0);
        end
    endtask

    task automatic test_reset_midframe();
        i_write = 1'b0; i_phy_addr = 5'h01; i_reg_addr = 5'h02; i_wdata = 16'h0000; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20 * CYC + $urandom_range(0, CYC - 1)) @(negedge clk);
        i_nreset = 1'b0;
        #1;
        m_rdata = 16'h0000;
        m_err   = 1'b0;
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", o_busy); end
        vectors++; if (o_mdc !== 1'b0) begin errors++; $display("FAIL mid_mdc got=%b exp=0", o_mdc); end
        vectors++; if (o_mdio_oe !== 1'b0) begin errors++; $display("FAIL mid_oe got=%b exp=0", o_mdio_oe); end
        vectors++; if (o_mdio_out !== 1'b1) begin errors++; $display("FAIL mid_out got=%b exp=1", o_mdio_out); end
        vectors++; if (o_rdata !== m_rdata) begin errors++; $display("FAIL mid_rdata got=%h exp=%h", o_rdata, m_rdata); end
        vectors++; if (o_rd_err !== m_err) begin errors++; $display("FAIL mid_rd_err got=%b exp=%b", o_rd_err, m_err); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL mid_done cyc=%0d got=%b exp=0", i, o_done); end
        end
        i_nreset = 1'b1;
        @(negedge clk);
        frame(1'b0, 5'($urandom), 5'h03, 16'h0000, 1'b1, 1'b1, 16'($urandom), -1, 1'b0);
    endtask

    initial begin
        i_nreset = 1'b0; i_start = 1'b0; i_write = 1'b0;
        i_phy_addr = 5'h00; i_reg_addr = 5'h00; i_wdata = 16'h0000; i_mdio_in = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_no_phy();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
